// File: rtl/response_router.sv
// response_router: return path for arbitrated requests.
// Each forward-path grant pushes its requester index into an in-order tag FIFO.
// Each accepted response pops the head tag and is written into that
// requester's registered output slot. Heads that name a slot at or above
// REQ_NUMBER (non power-of-two REQ_NUMBER only) are consumed and discarded.
// Optional feature macro: RESPONSE_ROUTER_ORPHAN_CHECK_EN enables the sticky
// orphan_err flag (response with no outstanding tag, or push into a full FIFO).
`timescale 1ns/1ps
module response_router #(
   parameter int RESP_WIDTH = 10,
   parameter int REQ_NUMBER = 16,
   parameter int DEPTH      = 4,
   localparam int SEL_W     = (REQ_NUMBER > 1) ? $clog2(REQ_NUMBER) : 1,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   issue_valid,
   input  logic [SEL_W-1:0]                       issue_select,
   output logic                                   issue_ready,
   input  logic                                   resp_valid,
   input  logic [RESP_WIDTH-1:0]                  resp_data,
   output logic                                   resp_ready,
   output logic [REQ_NUMBER-1:0][RESP_WIDTH-1:0]  out_data,
   output logic [REQ_NUMBER-1:0]                  out_valid,
   input  logic [REQ_NUMBER-1:0]                  out_ready,
   output logic                                   orphan_err
);

   // Handshakes: a tag is pushed on issue_valid && issue_ready, a response is
   // accepted on resp_valid && resp_ready, and slot i is consumed on
   // out_valid[i] && out_ready[i]. No ready waits on its own valid.

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [SEL_W:0]   REQ_LIM  = (SEL_W + 1)'(REQ_NUMBER);

   logic [SEL_W-1:0]                       r_tags [DEPTH];
   logic [PTR_W-1:0]                       r_wr_ptr;
   logic [PTR_W-1:0]                       r_rd_ptr;
   logic [CNT_W-1:0]                       r_count;
   logic [REQ_NUMBER-1:0]                  r_out_valid;
   logic [REQ_NUMBER-1:0][RESP_WIDTH-1:0]  r_out_data;

   logic [SEL_W-1:0]      w_head;
   logic                  w_head_in_range;
   logic                  w_slot_free;
   logic                  w_push;
   logic                  w_pop;
   logic [REQ_NUMBER-1:0] w_fill;

   assign w_head          = r_tags[r_rd_ptr];
   assign w_head_in_range = ({1'b0, w_head} < REQ_LIM);

   // Head slot can take a word if empty or being drained this cycle;
   // out-of-range heads are always free because their response is dropped.
   always_comb begin
      w_slot_free = 1'b1;
      if (w_head_in_range) begin
         w_slot_free = !r_out_valid[w_head] || out_ready[w_head];
      end
   end

   assign issue_ready = (r_count != FULL_CNT);
   assign resp_ready  = (r_count != '0) && w_slot_free;
   assign w_push      = issue_valid && issue_ready;
   assign w_pop       = resp_valid && resp_ready;

   // One-hot refill request for the slot addressed by the head tag.
   always_comb begin
      w_fill = '0;
      if (w_pop && w_head_in_range) begin
         w_fill[w_head] = 1'b1;
      end
   end

   // Tag storage: written at the write pointer, contents need no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tags[r_wr_ptr] <= issue_select;
      end
   end

   // Tag FIFO pointers and occupancy; simultaneous push and pop keep count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Output slots: a refill wins over a same-cycle consume.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= '0;
         r_out_data  <= '0;
      end else begin
         for (int i = 0; i < REQ_NUMBER; i++) begin
            if (w_fill[i]) begin
               r_out_valid[i] <= 1'b1;
               r_out_data[i]  <= resp_data;
            end else if (r_out_valid[i] && out_ready[i]) begin
               r_out_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef RESPONSE_ROUTER_ORPHAN_CHECK_EN
   logic r_orphan_err;

   // Sticky protocol error: response with nothing outstanding, or overflow push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_orphan_err <= 1'b0;
      end else if ((resp_valid && (r_count == '0)) ||
                   (issue_valid && (r_count == FULL_CNT))) begin
         r_orphan_err <= 1'b1;
      end
   end

   assign orphan_err = r_orphan_err;
`else
   assign orphan_err = 1'b0;
`endif

endmodule

// File: tb/tb_response_router.sv
// Directed bench for response_router: a 16-slot instance for routing,
// head-of-line blocking, FIFO wrap, orphan flag and reset, plus a 5-slot
// instance for the discarded out-of-range tag case.
`timescale 1ns/1ps
module tb_response_router;

  localparam int W = 14; // {slot[3:0], data[9:0]}

`ifdef RESPONSE_ROUTER_ORPHAN_CHECK_EN
  localparam logic EXP_ORPHAN = 1'b1;
`else
  localparam logic EXP_ORPHAN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  issue_valid;
  logic [3:0]            issue_select;
  logic                  issue_ready;
  logic                  resp_valid;
  logic [9:0]            resp_data;
  logic                  resp_ready;
  logic [15:0][9:0]      out_data;
  logic [15:0]           out_valid;
  logic [15:0]           out_ready;
  logic                  orphan_err;

  logic                  b_issue_valid;
  logic [2:0]            b_issue_select;
  logic                  b_issue_ready;
  logic                  b_resp_valid;
  logic [9:0]            b_resp_data;
  logic                  b_resp_ready;
  logic [4:0][9:0]       b_out_data;
  logic [4:0]            b_out_valid;
  logic [4:0]            b_out_ready;
  logic                  b_orphan_err;

  response_router #(.RESP_WIDTH(10), .REQ_NUMBER(16), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_select(issue_select), .issue_ready(issue_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .orphan_err(orphan_err)
  );

  response_router #(.RESP_WIDTH(10), .REQ_NUMBER(5), .DEPTH(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(b_issue_valid), .issue_select(b_issue_select), .issue_ready(b_issue_ready),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_ready(b_resp_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .orphan_err(b_orphan_err)
  );

  // ---------------- scoreboard state ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   tag_q[$];
  logic         mon_pend = 1'b0;
  logic [W-1:0] mon_item = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Delivery monitor: a handshake seen at a negedge must show up in the
  // expected slot at the following negedge.
  always @(negedge clk) begin
    if (mon_pend) begin
      chk("deliver_valid", 32'(out_valid[mon_item[13:10]]), 32'd1);
      chk("deliver_data", 32'(out_data[mon_item[13:10]]), 32'(mon_item[9:0]));
    end
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        mon_pend <= 1'b0;
      end else begin
        mon_item <= exp_q.pop_front();
        mon_pend <= 1'b1;
      end
    end else begin
      mon_pend <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] sel);
    issue_valid  = 1'b1;
    issue_select = sel;
    tag_q.push_back(sel);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic resp_one(input logic [9:0] d);
    logic [3:0] s;
    s = tag_q.pop_front();
    exp_q.push_back({s, d});
    resp_valid = 1'b1;
    resp_data  = d;
    #1;
    chk("resp_ready_one", 32'(resp_ready), 32'd1);
    tick();
    resp_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] s;
    logic [3:0] nsel;
    logic [9:0] d;

    rst_n = 1'b0;
    issue_valid = 1'b0; issue_select = '0; resp_valid = 1'b0; resp_data = '0;
    out_ready = '1;
    b_issue_valid = 1'b0; b_issue_select = '0; b_resp_valid = 1'b0; b_resp_data = '0;
    b_out_ready = '1;
    tick();
    tick();
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_orphan", 32'(orphan_err), 32'd0);
    chk("rst_b_resp_ready", 32'(b_resp_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // In-order routing to slots 3, 7, 3
    do_issue(4'd3); do_issue(4'd7); do_issue(4'd3);
    resp_one(10'h011);
    chk("route_mask1", 32'(out_valid), 32'h0008);
    resp_one(10'h022);
    chk("route_mask2", 32'(out_valid), 32'h0080);
    resp_one(10'h033);
    chk("route_mask3", 32'(out_valid), 32'h0008);
    tick();
    chk("route_drained", 32'(out_valid), 32'h0000);

    // Head-of-line blocking and same-cycle refill on slot 5
    out_ready[5] = 1'b0;
    do_issue(4'd5); do_issue(4'd5); do_issue(4'd2);
    resp_one(10'h0A5);
    s = tag_q.pop_front();
    exp_q.push_back({s, 10'h0B5});
    resp_valid = 1'b1; resp_data = 10'h0B5;
    #1;
    chk("hol_blocked", 32'(resp_ready), 32'd0);
    tick();
    chk("hol_slot5_valid", 32'(out_valid[5]), 32'd1);
    chk("hol_slot5_data", 32'(out_data[5]), 32'h0A5);
    chk("hol_still_blocked", 32'(resp_ready), 32'd0);
    out_ready[5] = 1'b1;
    #1;
    chk("hol_released", 32'(resp_ready), 32'd1);
    tick();
    resp_valid = 1'b0;
    chk("refill_valid", 32'(out_valid[5]), 32'd1);
    chk("refill_data", 32'(out_data[5]), 32'h0B5);
    resp_one(10'h0C2);
    chk("hol_then_slot2", 32'(out_valid), 32'h0004);
    tick();
    chk("hol_drained", 32'(out_valid), 32'h0000);

    // Fill the FIFO, then simultaneous push+pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      do_issue(4'(i));
      chk("fill_issue_ready", 32'(issue_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    resp_one(10'h100);
    chk("after_pop_ready", 32'(issue_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      nsel = 4'($urandom_range(0, 15));
      d    = 10'($urandom_range(0, 1023));
      s    = tag_q.pop_front();
      exp_q.push_back({s, d});
      tag_q.push_back(nsel);
      issue_valid = 1'b1; issue_select = nsel;
      resp_valid  = 1'b1; resp_data = d;
      #1;
      chk("wrap_resp_ready", 32'(resp_ready), 32'd1);
      chk("wrap_issue_ready", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
      resp_valid  = 1'b0;
    end
    do_issue(4'd12);
    chk("refull_issue_ready", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      resp_one(10'(10'h200 + i));
    end
    chk("empty_resp_ready", 32'(resp_ready), 32'd0);
    chk("empty_issue_ready", 32'(issue_ready), 32'd1);
    tick();

    // Out-of-range tag on the 5-slot instance is consumed and dropped
    b_issue_valid = 1'b1; b_issue_select = 3'd6;
    tick();
    b_issue_valid = 1'b0;
    b_resp_valid = 1'b1; b_resp_data = 10'h3C6;
    #1;
    chk("oor_resp_ready", 32'(b_resp_ready), 32'd1);
    tick();
    b_resp_valid = 1'b0;
    #1;
    chk("oor_no_valid", 32'(b_out_valid), 32'd0);
    chk("oor_popped", 32'(b_resp_ready), 32'd0);
    b_issue_valid = 1'b1; b_issue_select = 3'd4;
    tick();
    b_issue_valid = 1'b0;
    b_resp_valid = 1'b1; b_resp_data = 10'h2A4;
    tick();
    b_resp_valid = 1'b0;
    chk("b_slot4_valid", 32'(b_out_valid), 32'h10);
    chk("b_slot4_data", 32'(b_out_data[4]), 32'h2A4);

    // Response with empty FIFO: not accepted, orphan flag per build
    resp_valid = 1'b1; resp_data = 10'h3FF;
    #1;
    chk("orphan_resp_ready", 32'(resp_ready), 32'd0);
    tick();
    resp_valid = 1'b0;
    chk("orphan_set", 32'(orphan_err), 32'(EXP_ORPHAN));
    chk("orphan_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("orphan_sticky", 32'(orphan_err), 32'(EXP_ORPHAN));

    // Reset with three tags outstanding and slot 1 full
    out_ready[1] = 1'b0;
    do_issue(4'd1);
    resp_one(10'h111);
    chk("pre_rst_slot1", 32'(out_valid), 32'h0002);
    do_issue(4'd4); do_issue(4'd5); do_issue(4'd6);
    chk("pre_rst_issue_ready", 32'(issue_ready), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("mid_rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("mid_rst_data1", 32'(out_data[1]), 32'd0);
    chk("mid_rst_orphan", 32'(orphan_err), 32'd0);
    rst_n = 1'b1;
    tag_q.delete();
    out_ready = '1;
    tick();
    do_issue(4'd9);
    resp_one(10'h199);
    chk("post_rst_slot9", 32'(out_valid), 32'h0200);
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
